// File: rtl/store_buffer_pkg.sv
// Shared constants and types for the posted-write store buffer.
// Default depth, byte-enable encodings and the per-cycle FIFO operation code.
package store_buffer_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_LANES = 4;

    localparam logic [SB_LANES-1:0] BE_NONE = 4'b0000;
    localparam logic [SB_LANES-1:0] BE_WORD = 4'b1111;

    // Encoded as {push, pop}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } sb_op_e;

    function automatic sb_op_e sb_op(input logic push, input logic pop);
        return sb_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/sb_fwd_merge.sv
// Load-forwarding merge: each byte lane takes the youngest buffered store to the
// same word that enables that lane, otherwise the data-memory byte.
module sb_fwd_merge
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic [DEPTH-1:0][ADDR_W-3:0]   ent_addr,
    input  logic [DEPTH-1:0][DATA_W-1:0]   ent_data,
    input  logic [DEPTH-1:0][DATA_W/8-1:0] ent_be,
    input  logic [DEPTH-1:0]               ent_vld,
    input  logic [$clog2(DEPTH)-1:0]       head,
    input  logic [$clog2(DEPTH):0]         count,
    input  logic                           ld_en,
    input  logic [ADDR_W-3:0]              ld_word,
    input  logic [DATA_W-1:0]              mem_rdata,
    output logic [DATA_W-1:0]              ld_data,
    output logic                           fwd_hit
);

    localparam int LANES = DATA_W / 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]  word_match;
    logic [LANES-1:0]  lane_hit;

    // Word match is shared by all lanes; the lane scan only adds the byte enable.
    always_comb begin
        word_match = '0;
        for (int e = 0; e < DEPTH; e++)
            word_match[e] = ent_vld[e] && (ent_addr[e] == ld_word);
    end

    for (genvar b = 0; b < LANES; b++) begin : g_lane
        logic [7:0]       lane_byte;
        logic             lane_fwd;
        logic [PTR_W-1:0] idx;

        // Scan oldest to youngest from head; a younger hit overrides an older one.
        always_comb begin
            lane_byte = mem_rdata[8*b +: 8];
            lane_fwd  = 1'b0;
            idx       = head;
            for (int i = 0; i < DEPTH; i++) begin
                idx = head + PTR_W'(i);
                if ((CNT_W'(i) < count) && word_match[idx] && ent_be[idx][b]) begin
                    lane_byte = ent_data[idx][8*b +: 8];
                    lane_fwd  = 1'b1;
                end
            end
        end

        assign ld_data[8*b +: 8] = lane_byte;
        assign lane_hit[b]       = lane_fwd;
    end

    assign fwd_hit = ld_en & (|lane_hit);

endmodule

// File: rtl/store_buffer.sv
// In-order posted-write buffer between the CPU memory stage and data memory.
// Holds stores in a circular FIFO, drains the head over req/ack, forwards to loads.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_be,
    output logic                cpu_stall,
    input  logic                ld_en,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [DATA_W-1:0]   ld_data,
    output logic                fwd_hit,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    output logic                sb_empty
);

    localparam int LANES = DATA_W / 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][ADDR_W-3:0] ent_addr;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data;
    logic [DEPTH-1:0][LANES-1:0]  ent_be;
    logic [DEPTH-1:0]             ent_vld;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic empty;
    logic full;
    logic store_req;
    logic push;
    logic pop;

    // Stores are word-aligned; the byte offset bits carry no information here.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{cpu_addr[1:0], ld_addr[1:0]};

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign store_req = cpu_we & (cpu_be != BE_NONE);

    // A full buffer whose head is acked this cycle frees the slot the push needs.
    assign cpu_stall = store_req & full & ~mem_ack;
    assign push      = store_req & ~cpu_stall;
    assign mem_req   = ~empty;
    assign pop       = mem_req & mem_ack;
    assign sb_empty  = empty;

    assign mem_addr  = {ent_addr[head], 2'b00};
    assign mem_wdata = ent_data[head];
    assign mem_be    = ent_be[head];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            ent_vld  <= '0;
            ent_addr <= '0;
            ent_data <= '0;
            ent_be   <= '0;
        end else begin
            if (pop) begin
                ent_vld[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            // When full, tail == head: the push must win over the pop's clear.
            if (push) begin
                ent_addr[tail] <= cpu_addr[ADDR_W-1:2];
                ent_data[tail] <= cpu_wdata;
                ent_be[tail]   <= cpu_be;
                ent_vld[tail]  <= 1'b1;
                tail           <= tail + 1'b1;
            end
            case (sb_op(push, pop))
                OP_PUSH: count <= count + 1'b1;
                OP_POP:  count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    sb_fwd_merge #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd (
        .ent_addr  (ent_addr),
        .ent_data  (ent_data),
        .ent_be    (ent_be),
        .ent_vld   (ent_vld),
        .head      (head),
        .count     (count),
        .ld_en     (ld_en),
        .ld_word   (ld_addr[ADDR_W-1:2]),
        .mem_rdata (mem_rdata),
        .ld_data   (ld_data),
        .fwd_hit   (fwd_hit)
    );

endmodule
